emi_arbiter: RTL and testbench
==============================

Name: emi_arbiter

Overview:
- Shares the single external memory interface (EMI) between the instruction-fetch port (read-only, 64-bit beats) and the load/store port (read/write).
- Sits between the ifetch and memory-stage EMI ports and the memory controller.
- Holds at most one downstream transaction in flight; arbitration is fixed-priority (LS over IF), with an optional anti-starvation override.

Parameters:
- AW, 32, address width.
- DW, 64, data width.
- STARVE_LIMIT, 4, consecutive LS grants while IF waits before IF is forced (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_address  in  AW  IF beat address (bits [2:0] ignored)
- if_req  in  1  IF request, held until if_valid
- if_rdata  out  DW  IF read data
- if_valid  out  1  one-cycle IF completion
- ls_address  in  AW  LS beat address
- ls_req  in  1  LS request, held until ls_valid
- ls_rnw  in  1  1 = read, 0 = write
- ls_wdata  in  DW  write data
- ls_wbe  in  DW/8  byte enables
- ls_rdata  out  DW  LS read data
- ls_valid  out  1  one-cycle LS completion
- emi_address  out  AW  downstream address (registered)
- emi_req  out  1  downstream request (registered)
- emi_rnw  out  1  downstream direction
- emi_wdata  out  DW  downstream write data
- emi_wbe  out  DW/8  downstream byte enables
- emi_rdata  in  DW  downstream read data
- emi_valid  in  1  downstream one-cycle completion
- arb_owner  out  2  00 none, 01 IF, 10 LS

Behaviour:
- Reset (reset low, asynchronous): state IDLE, all outputs 0, starvation counter 0, abandon flag 0.
- State machine:
  - IDLE: sample requesters.
    - ls_req=1 -> LS_BUSY.
    - else if_req=1 -> IF_BUSY.
    - On the transition edge, register emi_address, emi_rnw (IF forces 1), emi_wdata, emi_wbe (IF forces 0) and set emi_req=1.
  - IF_BUSY / LS_BUSY:
    - emi_req and the emi_* fields stay stable until emi_valid.
    - On emi_valid: the owner's valid = 1 in the same cycle (combinational), unless the abandon flag is set.
    - At the next edge: emi_req=0, state IDLE.
- Turnaround: at least one IDLE cycle between transactions. Minimum latency is req seen at edge N -> emi_req at N+1 -> valid in the same cycle as emi_valid.
- Read data: if_rdata and ls_rdata both equal emi_rdata at all times (unqualified). Only valid qualifies the data.
- Abandon:
  - The owner dropping req while busy sets the abandon flag.
  - The downstream transaction still completes.
  - The owner's valid is suppressed on completion; the flag clears on return to IDLE.
  - A new req from the same requester during abandon is not serviced until IDLE.
- Simultaneous if_req and ls_req in IDLE: LS wins, except under the starvation override.
- emi_valid outside BUSY: ignored.
- Requester valid is never asserted without emi_valid.
- Address and write fields must remain stable on the EMI while busy, regardless of requester changes.

Optional Feature:
- EMI_ARB_STARVE_EN defined:
  - A 3-bit saturating counter increments on each LS grant taken while if_req=1.
  - It resets on any IF grant or on if_req=0 in IDLE.
  - When count ≥ STARVE_LIMIT and if_req=1 in IDLE, IF is granted even if ls_req=1.
- Undefined: pure LS-over-IF fixed priority; no counter logic.

Decomposition:
- Shared package/header: owner encoding (ARB_NONE=0, ARB_IF=1, ARB_LS=2), state encoding (IDLE, IF_BUSY, LS_BUSY), default AW/DW.
- No sub-module needed. The optional starvation counter stays inline under the macro.

Test Plan:
- Lone IF read:
  - Stimulus: if_req=1, if_address=0x100, EMI responds 3 cycles after emi_req with rdata 0x0123456789ABCDEF.
  - Required: emi_address=0x100, emi_rnw=1, emi_wbe=0; if_valid pulses once with that data; ls_valid stays 0.
- Simultaneous requests:
  - Stimulus: if_req (0x200) and ls_req write (0x300, wdata 0xDEADBEEF00000000, wbe 0xF0) rise together.
  - Required: LS is issued first with emi_rnw=0 and wbe=0xF0; IF is issued after one IDLE cycle; each valid pulses exactly once.
- Abandon:
  - Stimulus: IF granted at 0x060, if_req dropped before emi_valid; if_req re-raised at 0x064.
  - Required: no if_valid for 0x060; emi_address=0x064 issued only after the 0x060 completion.
- Reset mid-transaction:
  - Stimulus: reset asserted low while LS_BUSY.
  - Required: emi_req, ls_valid and arb_owner go 0 immediately (asynchronously); a stray emi_valid after reset release is ignored.
- Stability:
  - Stimulus: while busy, change ls_address and ls_wdata every cycle.
  - Required: emi_address and emi_wdata stay unchanged until emi_valid.
- Starvation (EMI_ARB_STARVE_EN, STARVE_LIMIT=4):
  - Stimulus: ls_req and if_req held continuously.
  - Required: IF is granted on the 5th arbitration; without the macro, IF is never granted while ls_req=1.

Source files
------------

// File: rtl/emi_arbiter_pkg.sv
// Shared encodings for the EMI arbiter: owner code, FSM state code and default bus widths.
package emi_arbiter_pkg;

  localparam int EMI_AW_DEF           = 32;
  localparam int EMI_DW_DEF           = 64;
  localparam int EMI_STARVE_LIMIT_DEF = 4;

  localparam logic [1:0] ARB_NONE = 2'd0;
  localparam logic [1:0] ARB_IF   = 2'd1;
  localparam logic [1:0] ARB_LS   = 2'd2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_BUSY = 2'd1;
  localparam logic [1:0] ST_LS_BUSY = 2'd2;

  function automatic logic [1:0] owner_of(input logic [1:0] state);
    case (state)
      ST_IF_BUSY: owner_of = ARB_IF;
      ST_LS_BUSY: owner_of = ARB_LS;
      default:    owner_of = ARB_NONE;
    endcase
  endfunction

endpackage

// File: rtl/emi_arbiter.sv
// emi_arbiter: one EMI shared by ifetch and load/store, LS priority, one transaction in flight; EMI_ARB_STARVE_EN adds IF anti-starvation.
// Latency: req sampled at edge N -> emi_req at N+1 -> requester valid with emi_valid; requesters hold req until valid (no other backpressure).
module emi_arbiter
  import emi_arbiter_pkg::*;
#(
  parameter int AW           = EMI_AW_DEF,
  parameter int DW           = EMI_DW_DEF,
  parameter int STARVE_LIMIT = EMI_STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   if_address,
  input  logic            if_req,
  output logic [DW-1:0]   if_rdata,
  output logic            if_valid,
  input  logic [AW-1:0]   ls_address,
  input  logic            ls_req,
  input  logic            ls_rnw,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wbe,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_valid,
  output logic [AW-1:0]   emi_address,
  output logic            emi_req,
  output logic            emi_rnw,
  output logic [DW-1:0]   emi_wdata,
  output logic [DW/8-1:0] emi_wbe,
  input  logic [DW-1:0]   emi_rdata,
  input  logic            emi_valid,
  output logic [1:0]      arb_owner
);

  typedef struct packed {
    logic [AW-1:0]   address;
    logic            rnw;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wbe;
  } emi_cmd_t;

  logic [1:0] r_state;
  logic       r_emi_req;
  logic       r_abandon;
  emi_cmd_t   r_cmd;

  logic w_idle;
  logic w_if_busy;
  logic w_ls_busy;
  logic w_owner_req;
  logic w_abandon;
  logic w_force_if;
  logic w_grant_if;
  logic w_grant_ls;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_if_busy = (r_state == ST_IF_BUSY);
  assign w_ls_busy = (r_state == ST_LS_BUSY);

`ifdef EMI_ARB_STARVE_EN
  logic [2:0] r_starve_cnt;

  assign w_force_if = if_req && (int'(r_starve_cnt) >= STARVE_LIMIT);

  // Counts LS wins over a waiting IF; any IF win or IF going quiet clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (w_idle) begin
      if (w_grant_if || !if_req) begin
        r_starve_cnt <= '0;
      end else if (w_grant_ls && (r_starve_cnt != 3'd7)) begin
        r_starve_cnt <= r_starve_cnt + 3'd1;
      end
    end
  end
`else
  logic w_unused_starve_limit;

  assign w_force_if            = 1'b0;
  assign w_unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  assign w_grant_if = w_idle && if_req && (!ls_req || w_force_if);
  assign w_grant_ls = w_idle && ls_req && !w_grant_if;

  // A requester that has let go of req (now or earlier in this transaction) gets no valid.
  assign w_owner_req = (w_if_busy && if_req) || (w_ls_busy && ls_req);
  assign w_abandon   = r_abandon || !w_owner_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_emi_req <= 1'b0;
      r_abandon <= 1'b0;
      r_cmd     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_ls) begin
            r_state   <= ST_LS_BUSY;
            r_emi_req <= 1'b1;
            r_cmd     <= '{address: ls_address, rnw: ls_rnw, wdata: ls_wdata, wbe: ls_wbe};
          end else if (w_grant_if) begin
            r_state   <= ST_IF_BUSY;
            r_emi_req <= 1'b1;
            r_cmd     <= '{address: if_address, rnw: 1'b1, wdata: '0, wbe: '0};
          end
        end
        ST_IF_BUSY, ST_LS_BUSY: begin
          if (emi_valid) begin
            r_state   <= ST_IDLE;
            r_emi_req <= 1'b0;
            r_abandon <= 1'b0;
          end else if (!w_owner_req) begin
            r_abandon <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_emi_req <= 1'b0;
          r_abandon <= 1'b0;
        end
      endcase
    end
  end

  assign if_valid    = w_if_busy && emi_valid && !w_abandon;
  assign ls_valid    = w_ls_busy && emi_valid && !w_abandon;
  assign if_rdata    = emi_rdata;
  assign ls_rdata    = emi_rdata;
  assign emi_req     = r_emi_req;
  assign emi_address = r_cmd.address;
  assign emi_rnw     = r_cmd.rnw;
  assign emi_wdata   = r_cmd.wdata;
  assign emi_wbe     = r_cmd.wbe;
  assign arb_owner   = owner_of(r_state);

endmodule

// File: tb/tb_emi_arbiter.sv
// Self-checking bench for emi_arbiter: vector table of single transactions plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_emi_arbiter;
  import emi_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int WB = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] if_address;
  logic          if_req;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic [AW-1:0] ls_address;
  logic          ls_req;
  logic          ls_rnw;
  logic [DW-1:0] ls_wdata;
  logic [WB-1:0] ls_wbe;
  logic [DW-1:0] ls_rdata;
  logic          ls_valid;
  logic [AW-1:0] emi_address;
  logic          emi_req;
  logic          emi_rnw;
  logic [DW-1:0] emi_wdata;
  logic [WB-1:0] emi_wbe;
  logic [DW-1:0] emi_rdata;
  logic          emi_valid;
  logic [1:0]    arb_owner;

  emi_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_address(if_address), .if_req(if_req), .if_rdata(if_rdata), .if_valid(if_valid),
    .ls_address(ls_address), .ls_req(ls_req), .ls_rnw(ls_rnw), .ls_wdata(ls_wdata),
    .ls_wbe(ls_wbe), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
    .emi_address(emi_address), .emi_req(emi_req), .emi_rnw(emi_rnw), .emi_wdata(emi_wdata),
    .emi_wbe(emi_wbe), .emi_rdata(emi_rdata), .emi_valid(emi_valid), .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    owner;
    logic [AW-1:0] addr;
    logic          rnw;
    logic [DW-1:0] wdata;
    logic [WB-1:0] wbe;
  } iss_t;

  typedef struct packed {
    logic [1:0]    owner;
    logic [DW-1:0] data;
  } cpl_t;

  typedef struct {
    logic          is_ls;
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [WB-1:0] wbe;
    int            lat;
    logic [DW-1:0] rdata;
    logic [1:0]    exp_owner;
    logic          exp_rnw;
    logic [WB-1:0] exp_wbe;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  iss_t exp_iss[$];
  iss_t obs_iss[$];
  cpl_t exp_cpl[$];
  cpl_t obs_cpl[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_req = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Samples DUT outputs on the falling edge, returns 1ns after the next rising edge.
  task automatic step();
    iss_t oi;
    cpl_t oc;
    @(negedge clk);
    if (emi_req && !prev_req) begin
      oi = '{arb_owner, emi_address, emi_rnw, emi_wdata, emi_wbe};
      obs_iss.push_back(oi);
    end
    if (if_valid) begin
      oc = '{ARB_IF, if_rdata};
      obs_cpl.push_back(oc);
    end
    if (ls_valid) begin
      oc = '{ARB_LS, ls_rdata};
      obs_cpl.push_back(oc);
    end
    prev_req = emi_req;
    @(posedge clk);
    #1;
  endtask

  task automatic push_iss(input logic [1:0] o, input logic [AW-1:0] a, input logic rnw,
                          input logic [DW-1:0] wd, input logic [WB-1:0] be);
    iss_t e;
    e = '{o, a, rnw, wd, be};
    exp_iss.push_back(e);
  endtask

  // Called 1ns after the edge that raised emi_req; returns 1ns after the completing edge.
  task automatic respond(input logic [DW-1:0] rd, input int lat, input logic exp_valid, input logic [1:0] own);
    cpl_t e;
    repeat (lat) step();
    emi_valid = 1'b1;
    emi_rdata = rd;
    if (exp_valid) begin
      e = '{own, rd};
      exp_cpl.push_back(e);
    end
    #1;
    chk("rdata_if_passthru", 128'(if_rdata), 128'(rd));
    chk("rdata_ls_passthru", 128'(ls_rdata), 128'(rd));
    step();
    emi_valid = 1'b0;
    emi_rdata = {$urandom(), $urandom()};
  endtask

  task automatic drain(input string tag);
    chk({tag, "_issue_count"}, 128'(obs_iss.size()), 128'(exp_iss.size()));
    while (obs_iss.size() > 0 && exp_iss.size() > 0)
      chk({tag, "_issue"}, 128'(obs_iss.pop_front()), 128'(exp_iss.pop_front()));
    chk({tag, "_valid_count"}, 128'(obs_cpl.size()), 128'(exp_cpl.size()));
    while (obs_cpl.size() > 0 && exp_cpl.size() > 0)
      chk({tag, "_valid"}, 128'(obs_cpl.pop_front()), 128'(exp_cpl.pop_front()));
    obs_iss.delete();
    exp_iss.delete();
    obs_cpl.delete();
    exp_cpl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic [1:0] eo;
    logic [DW-1:0] hold_wdata;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 64'h0, 8'hFF, 3, 64'h0123_4567_89AB_CDEF,
                ARB_IF, 1'b1, 8'h00, 64'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0300, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1, 64'h0,
                ARB_LS, 1'b0, 8'hF0, 64'hDEAD_BEEF_0000_0000};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0408, 64'h0, 8'h0F, 2, 64'hA5A5_5A5A_0F0F_F0F0,
                ARB_LS, 1'b1, 8'h0F, 64'h0};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 64'h0, 8'hFF, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                ARB_IF, 1'b1, 8'h00, 64'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 64'h1122_3344_5566_7788, 8'h01, 5, 64'h8877,
                ARB_LS, 1'b0, 8'h01, 64'h1122_3344_5566_7788};

    reset = 1'b0;
    if_address = '0; if_req = 1'b0;
    ls_address = '0; ls_req = 1'b0; ls_rnw = 1'b0; ls_wdata = '0; ls_wbe = '0;
    emi_rdata = '0; emi_valid = 1'b0;
    #2;
    chk("rst_emi_req", 128'(emi_req), 128'(0));
    chk("rst_emi_addr", 128'(emi_address), 128'(0));
    chk("rst_emi_rnw", 128'(emi_rnw), 128'(0));
    chk("rst_emi_wdata", 128'(emi_wdata), 128'(0));
    chk("rst_emi_wbe", 128'(emi_wbe), 128'(0));
    chk("rst_owner", 128'(arb_owner), 128'(ARB_NONE));
    chk("rst_if_valid", 128'(if_valid), 128'(0));
    chk("rst_ls_valid", 128'(ls_valid), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      if (v.is_ls) begin
        ls_req = 1'b1; ls_address = v.addr; ls_rnw = v.rnw; ls_wdata = v.wdata; ls_wbe = v.wbe;
      end else begin
        if_req = 1'b1; if_address = v.addr; ls_wbe = v.wbe;
      end
      push_iss(v.exp_owner, v.addr, v.exp_rnw, v.exp_wdata, v.exp_wbe);
      step();
      chk($sformatf("vec%0d_emi_req", i), 128'(emi_req), 128'(1));
      chk($sformatf("vec%0d_owner", i), 128'(arb_owner), 128'(v.exp_owner));
      respond(v.rdata, v.lat, 1'b1, v.exp_owner);
      chk($sformatf("vec%0d_req_drop", i), 128'(emi_req), 128'(0));
      if_req = 1'b0; ls_req = 1'b0; ls_wdata = '0; ls_wbe = '0;
      step();
      drain($sformatf("vec%0d", i));
    end

    // Simultaneous requests: LS first, then IF after one idle cycle.
    if_req = 1'b1; if_address = 32'h200;
    ls_req = 1'b1; ls_address = 32'h300; ls_rnw = 1'b0;
    ls_wdata = 64'hDEAD_BEEF_0000_0000; ls_wbe = 8'hF0;
    push_iss(ARB_LS, 32'h300, 1'b0, 64'hDEAD_BEEF_0000_0000, 8'hF0);
    step();
    chk("sim_owner_ls", 128'(arb_owner), 128'(ARB_LS));
    respond(64'h1111_2222_3333_4444, 2, 1'b1, ARB_LS);
    ls_req = 1'b0; ls_wdata = '0; ls_wbe = '0;
    chk("sim_idle_gap", 128'(emi_req), 128'(0));
    push_iss(ARB_IF, 32'h200, 1'b1, 64'h0, 8'h00);
    step();
    chk("sim_owner_if", 128'(arb_owner), 128'(ARB_IF));
    respond(64'h5555_6666_7777_8888, 1, 1'b1, ARB_IF);
    if_req = 1'b0;
    step();
    drain("sim");

    // Abandon: 0x060 dropped mid-flight, 0x064 re-raised before the old one completes.
    if_req = 1'b1; if_address = 32'h060;
    push_iss(ARB_IF, 32'h060, 1'b1, 64'h0, 8'h00);
    step();
    chk("ab_owner", 128'(arb_owner), 128'(ARB_IF));
    step();
    if_req = 1'b0;
    step();
    step();
    if_req = 1'b1; if_address = 32'h064;
    step();
    chk("ab_addr_hold", 128'(emi_address), 128'(32'h060));
    chk("ab_req_hold", 128'(emi_req), 128'(1));
    respond(64'h0BAD_0BAD_0BAD_0BAD, 0, 1'b0, ARB_IF);
    chk("ab_idle_gap", 128'(emi_req), 128'(0));
    push_iss(ARB_IF, 32'h064, 1'b1, 64'h0, 8'h00);
    step();
    chk("ab_addr_new", 128'(emi_address), 128'(32'h064));
    respond(64'h6464_6464_6464_6464, 2, 1'b1, ARB_IF);
    if_req = 1'b0;
    step();
    drain("ab");

    // Stability: LS fields churn while the transaction is outstanding.
    hold_wdata = 64'hCAFE_F00D_CAFE_F00D;
    ls_req = 1'b1; ls_address = 32'h500; ls_rnw = 1'b0; ls_wdata = hold_wdata; ls_wbe = 8'h3C;
    push_iss(ARB_LS, 32'h500, 1'b0, hold_wdata, 8'h3C);
    step();
    for (int k = 0; k < 4; k++) begin
      ls_address = $urandom();
      ls_wdata   = {$urandom(), $urandom()};
      ls_wbe     = 8'($urandom());
      ls_rnw     = ~ls_rnw;
      step();
      chk($sformatf("stab%0d_addr", k), 128'(emi_address), 128'(32'h500));
      chk($sformatf("stab%0d_wdata", k), 128'(emi_wdata), 128'(hold_wdata));
      chk($sformatf("stab%0d_wbe", k), 128'(emi_wbe), 128'(8'h3C));
    end
    respond(64'h0, 0, 1'b1, ARB_LS);
    ls_req = 1'b0; ls_wdata = '0; ls_wbe = '0; ls_rnw = 1'b0;
    step();
    drain("stab");

    // Reset while LS_BUSY, with emi_valid already asserted.
    ls_req = 1'b1; ls_address = 32'h900; ls_rnw = 1'b1; ls_wbe = 8'hFF;
    push_iss(ARB_LS, 32'h900, 1'b1, 64'h0, 8'hFF);
    step();
    chk("rst_busy_owner", 128'(arb_owner), 128'(ARB_LS));
    step();
    emi_valid = 1'b1; emi_rdata = 64'h9999_0000_9999_0000;
    #1;
    chk("rst_pre_valid", 128'(ls_valid), 128'(1));
    #1 reset = 1'b0;
    #1;
    chk("rst_async_req", 128'(emi_req), 128'(0));
    chk("rst_async_valid", 128'(ls_valid), 128'(0));
    chk("rst_async_owner", 128'(arb_owner), 128'(ARB_NONE));
    ls_req = 1'b0; ls_wbe = '0;
    step();
    reset = 1'b1;
    step();
    chk("rst_stray_ls_valid", 128'(ls_valid), 128'(0));
    chk("rst_stray_if_valid", 128'(if_valid), 128'(0));
    chk("rst_stray_req", 128'(emi_req), 128'(0));
    emi_valid = 1'b0;
    step();
    drain("rst");

    // Both requesters held: IF wins the 5th arbitration only with the starvation override.
    if_req = 1'b1; if_address = 32'h700;
    ls_req = 1'b1; ls_address = 32'h800; ls_rnw = 1'b1; ls_wbe = 8'hFF; ls_wdata = '0;
    for (int a = 0; a < 6; a++) begin
`ifdef EMI_ARB_STARVE_EN
      eo = (a == 4) ? ARB_IF : ARB_LS;
`else
      eo = ARB_LS;
`endif
      if (eo == ARB_IF) push_iss(ARB_IF, 32'h700, 1'b1, 64'h0, 8'h00);
      else              push_iss(ARB_LS, 32'h800, 1'b1, 64'h0, 8'hFF);
      step();
      chk($sformatf("stv%0d_owner", a), 128'(arb_owner), 128'(eo));
      respond(64'(a) + 64'h5000, 0, 1'b1, eo);
    end
    ls_req = 1'b0; ls_wbe = '0;
    push_iss(ARB_IF, 32'h700, 1'b1, 64'h0, 8'h00);
    step();
    chk("stv_if_after_ls", 128'(arb_owner), 128'(ARB_IF));
    respond(64'h7777, 1, 1'b1, ARB_IF);
    if_req = 1'b0;
    step();
    drain("stv");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
